// File: rtl/aes_mode_sched_if.sv
// Requester, core and completion signals of aes_mode_sched bundled as one interface.
interface aes_mode_sched_if #(
    parameter int CNT_W = 3
);
    logic             req0;
    logic [1:0]       mode0;
    logic             ack0;
    logic             req1;
    logic [1:0]       mode1;
    logic             ack1;
    logic             core_ready;
    logic             core_start;
    logic [1:0]       core_mode;
    logic             core_done;
    logic             done_valid;
    logic [1:0]       done_mode;
    logic             done_id;
    logic             flush;
    logic             idle;
    logic [CNT_W-1:0] inflight;
    logic             err_underflow;

    modport slave (
        input  req0, mode0, req1, mode1, core_ready, core_done, flush,
        output ack0, ack1, core_start, core_mode, done_valid, done_mode, done_id,
               idle, inflight, err_underflow
    );

    modport master (
        output req0, mode0, req1, mode1, core_ready, core_done, flush,
        input  ack0, ack1, core_start, core_mode, done_valid, done_mode, done_id,
               idle, inflight, err_underflow
    );
endinterface

// File: rtl/aes_mode_sched.sv
// Two-requester scheduler for a shared AES-256 core with in-order {id, mode} tag tracking.
// Define AES_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module aes_mode_sched #(
    parameter int DEPTH = 5,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             resetn,
    aes_mode_sched_if.slave sched
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;
    typedef struct packed {
        logic       id;
        logic [1:0] mode;
    } tag_t;

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    tag_t             mem_q [DEPTH];
    tag_t             mem_d [DEPTH];
    logic             ack0_q, ack0_d, ack1_q, ack1_d, start_q, start_d;
    logic [1:0]       mode_q, mode_d;
    logic             dv_q, dv_d, err_q, err_d;
    tag_t             dtag_q, dtag_d;
    logic             elig0, elig1, pop, issue, grant0, grant1;
`ifndef AES_SCHED_FIXED_PRIO_EN
    logic             rr_q, rr_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // A requester acked this cycle is still holding req for the same block.
        elig0  = sched.req0 & ~ack0_q;
        elig1  = sched.req1 & ~ack1_q;
        pop    = sched.core_done & (cnt_q != '0);
        // When full, a same-edge pop frees the slot the new push takes.
        issue  = (state_q != S_FLUSH) & ~sched.flush & sched.core_ready &
                 ((cnt_q < DEPTH_C) | pop) & (elig0 | elig1);
`ifdef AES_SCHED_FIXED_PRIO_EN
        grant0 = issue & elig0;
`else
        grant0 = issue & elig0 & (~elig1 | ~rr_q);
        rr_d   = issue ? grant0 : rr_q;
`endif
        grant1 = issue & ~grant0;

        ack0_d  = grant0;
        ack1_d  = grant1;
        start_d = issue;
        mode_d  = issue ? (grant0 ? sched.mode0 : sched.mode1) : mode_q;

        mem_d  = mem_q;
        tail_d = tail_q;
        if (issue) begin
            mem_d[tail_q] = '{id: grant1, mode: mode_d};
            tail_d        = ptr_inc(tail_q);
        end
        head_d = pop ? ptr_inc(head_q) : head_q;
        dv_d   = pop;
        dtag_d = pop ? mem_q[head_q] : dtag_q;
        err_d  = err_q | (sched.core_done & (cnt_q == '0));

        cnt_d = cnt_q;
        if (issue && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !issue) cnt_d = cnt_q - 1'b1;

        state_d = state_q;
        if (sched.flush) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  if (issue) state_d = S_RUN;
                S_RUN:   if (cnt_d == '0) state_d = S_IDLE;
                S_FLUSH: if (cnt_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            start_q <= 1'b0;
            mode_q  <= '0;
            dv_q    <= 1'b0;
            dtag_q  <= '0;
            err_q   <= 1'b0;
`ifndef AES_SCHED_FIXED_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            dv_q    <= dv_d;
            dtag_q  <= dtag_d;
            err_q   <= err_d;
`ifndef AES_SCHED_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign sched.ack0          = ack0_q;
    assign sched.ack1          = ack1_q;
    assign sched.core_start    = start_q;
    assign sched.core_mode     = mode_q;
    assign sched.done_valid    = dv_q;
    assign sched.done_mode     = dtag_q.mode;
    assign sched.done_id       = dtag_q.id;
    assign sched.idle          = (state_q == S_IDLE) && (cnt_q == '0);
    assign sched.inflight      = cnt_q;
    assign sched.err_underflow = err_q;
endmodule

// File: tb/tb_aes_mode_sched.sv
// Self-checking bench for aes_mode_sched: directed scenarios plus randomized traffic vs a queue model.
module tb_aes_mode_sched;
    localparam int DEPTH = 5;
    localparam int CNT_W = 3;
    localparam logic [13:0] RST_VEC = 14'h010;  // only idle set

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    aes_mode_sched_if #(.CNT_W(CNT_W)) bus_if ();
    aes_mode_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .sched(bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding tags as a FIFO of {id, mode}.
    logic [2:0] mq[$];
    bit         m_ack0, m_ack1, m_start, m_dv, m_did, m_err, m_rr, m_fl;
    bit   [1:0] m_mode, m_dmode;

    task automatic model_step();
        bit e0, e1, pop, can, g0, g1;
        int sz;
        logic [2:0] t;
        if (!resetn) begin
            mq.delete();
            {m_ack0, m_ack1, m_start, m_dv, m_did, m_err, m_rr, m_fl} = '0;
            m_mode = 0;
            m_dmode = 0;
            return;
        end
        sz  = mq.size();
        e0  = bus_if.req0 && !m_ack0;
        e1  = bus_if.req1 && !m_ack1;
        pop = bus_if.core_done && sz > 0;
        can = !m_fl && !bus_if.flush && bus_if.core_ready && (sz < DEPTH || pop) && (e0 || e1);
`ifdef AES_SCHED_FIXED_PRIO_EN
        g0 = can && e0;
`else
        g0 = can && e0 && (!e1 || !m_rr);
`endif
        g1 = can && !g0;
        m_dv = pop;
        if (pop) begin
            t = mq.pop_front();
            m_did = t[2];
            m_dmode = t[1:0];
        end
        if (bus_if.core_done && sz == 0) m_err = 1'b1;
        if (can) begin
            m_mode = g0 ? bus_if.mode0 : bus_if.mode1;
            mq.push_back({g1, m_mode});
            m_rr = g0;
        end
        m_ack0 = g0;
        m_ack1 = g1;
        m_start = can;
        m_fl = bus_if.flush || (m_fl && sz != 0);
    endtask

    function automatic logic [13:0] exp_vec();
        logic [CNT_W-1:0] c;
        c = CNT_W'(mq.size());
        return {m_ack0, m_ack1, m_start, m_mode, m_dv, m_dv ? m_dmode : 2'b00,
                m_dv ? m_did : 1'b0, !m_fl && mq.size() == 0, c, m_err};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus_if.ack0, bus_if.ack1, bus_if.core_start, bus_if.core_mode, bus_if.done_valid,
                bus_if.done_valid ? bus_if.done_mode : 2'b00,
                bus_if.done_valid ? bus_if.done_id : 1'b0,
                bus_if.idle, bus_if.inflight, bus_if.err_underflow};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus_if.req0 = 0; bus_if.mode0 = 0; bus_if.req1 = 0; bus_if.mode1 = 0;
        bus_if.core_ready = 0; bus_if.core_done = 0; bus_if.flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        bus_if.req0 = 1; bus_if.core_ready = 1; bus_if.core_done = 1;
        tick();
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), RST_VEC);
        end
        clear_inputs();
        resetn = 1;
        tick();
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), RST_VEC);
        end
    endtask

    task automatic test_single_issue();
        do_reset();
        bus_if.req0 = 1; bus_if.mode0 = 1; bus_if.core_ready = 1;
        tick();
        checks++;
        if ({bus_if.ack0, bus_if.ack1, bus_if.core_start, bus_if.core_mode, bus_if.inflight, bus_if.idle}
            !== {1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0}) begin
            failures++; $display("FAIL single_issue ack0=%b start=%b mode=%0d infl=%0d idle=%b exp 1,1,1,1,0",
                bus_if.ack0, bus_if.core_start, bus_if.core_mode, bus_if.inflight, bus_if.idle);
        end
        bus_if.req0 = 0;
        tick();
        checks++;
        if ({bus_if.ack0, bus_if.core_start, bus_if.inflight} !== {1'b0, 1'b0, 3'd1}) begin
            failures++; $display("FAIL single_pulse ack0=%b start=%b infl=%0d exp 0,0,1",
                bus_if.ack0, bus_if.core_start, bus_if.inflight);
        end
        bus_if.core_done = 1;
        tick();
        bus_if.core_done = 0;
        checks++;
        if ({bus_if.done_valid, bus_if.done_id, bus_if.done_mode, bus_if.inflight, bus_if.idle}
            !== {1'b1, 1'b0, 2'd1, 3'd0, 1'b1}) begin
            failures++; $display("FAIL single_done dv=%b id=%b mode=%0d infl=%0d idle=%b exp 1,0,1,0,1",
                bus_if.done_valid, bus_if.done_id, bus_if.done_mode, bus_if.inflight, bus_if.idle);
        end
    endtask

    task automatic test_contention();
        int order[$];
        int exp_id[5] = '{0, 1, 0, 1, 0};
        do_reset();
        bus_if.req0 = 1; bus_if.mode0 = 0; bus_if.req1 = 1; bus_if.mode1 = 1; bus_if.core_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.ack0) order.push_back(0);
            if (bus_if.ack1) order.push_back(1);
        end
        checks++;
        if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 0 ||
            order[3] != 1 || order[4] != 0 || bus_if.inflight !== 3'd5) begin
            failures++; $display("FAIL contention_order grants=%0d infl=%0d exp 5 grants 0,1,0,1,0 infl=5",
                order.size(), bus_if.inflight);
        end
        bus_if.req0 = 0; bus_if.req1 = 0;
        for (int i = 0; i < 5; i++) begin
            bus_if.core_done = 1;
            tick();
            checks++;
            if ({bus_if.done_valid, bus_if.done_id, bus_if.done_mode} !==
                {1'b1, exp_id[i][0], 1'b0, exp_id[i][0]}) begin
                failures++; $display("FAIL contention_done[%0d] dv=%b id=%b mode=%0d exp id=%0d",
                    i, bus_if.done_valid, bus_if.done_id, bus_if.done_mode, exp_id[i]);
            end
        end
        bus_if.core_done = 0;
        checks++;
        if ({bus_if.idle, bus_if.inflight} !== {1'b1, 3'd0}) begin
            failures++; $display("FAIL contention_idle idle=%b infl=%0d exp 1,0", bus_if.idle, bus_if.inflight);
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        bus_if.req0 = 1; bus_if.mode0 = 2; bus_if.core_ready = 1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus_if.inflight !== 3'd5) begin
            failures++; $display("FAIL full_fill infl=%0d exp 5", bus_if.inflight);
        end
        bus_if.req0 = 0; bus_if.req1 = 1; bus_if.mode1 = 3; bus_if.core_done = 1;
        tick();
        checks++;
        if ({bus_if.ack1, bus_if.core_start, bus_if.core_mode, bus_if.done_valid, bus_if.done_id,
             bus_if.done_mode, bus_if.inflight} !== {1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 2'd2, 3'd5}) begin
            failures++; $display("FAIL full_simul ack1=%b start=%b cmode=%0d dv=%b id=%b dmode=%0d infl=%0d exp 1,1,3,1,0,2,5",
                bus_if.ack1, bus_if.core_start, bus_if.core_mode, bus_if.done_valid, bus_if.done_id,
                bus_if.done_mode, bus_if.inflight);
        end
        bus_if.req1 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checks++;
        if ({bus_if.done_valid, bus_if.done_id, bus_if.done_mode, bus_if.idle} !== {1'b1, 1'b1, 2'd3, 1'b1}) begin
            failures++; $display("FAIL full_last dv=%b id=%b mode=%0d idle=%b exp 1,1,3,1",
                bus_if.done_valid, bus_if.done_id, bus_if.done_mode, bus_if.idle);
        end
        bus_if.core_done = 0;
    endtask

    task automatic test_flush();
        do_reset();
        bus_if.req0 = 1; bus_if.mode0 = 1; bus_if.core_ready = 1;
        for (int i = 0; i < 5; i++) tick();
        bus_if.flush = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus_if.ack0, bus_if.inflight, bus_if.idle} !== {1'b0, 3'd3, 1'b0}) begin
                failures++; $display("FAIL flush_hold[%0d] ack0=%b infl=%0d idle=%b exp 0,3,0",
                    i, bus_if.ack0, bus_if.inflight, bus_if.idle);
            end
        end
        bus_if.core_done = 1;
        for (int i = 0; i < 3; i++) tick();
        bus_if.core_done = 0;
        checks++;
        if ({bus_if.ack0, bus_if.inflight, bus_if.idle} !== {1'b0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL flush_drain ack0=%b infl=%0d idle=%b exp 0,0,0",
                bus_if.ack0, bus_if.inflight, bus_if.idle);
        end
        bus_if.flush = 0;
        tick();
        checks++;
        if ({bus_if.ack0, bus_if.idle} !== {1'b0, 1'b1}) begin
            failures++; $display("FAIL flush_exit ack0=%b idle=%b exp 0,1", bus_if.ack0, bus_if.idle);
        end
        tick();
        checks++;
        if ({bus_if.ack0, bus_if.core_start, bus_if.inflight} !== {1'b1, 1'b1, 3'd1}) begin
            failures++; $display("FAIL flush_regrant ack0=%b start=%b infl=%0d exp 1,1,1",
                bus_if.ack0, bus_if.core_start, bus_if.inflight);
        end
        bus_if.req0 = 0;
    endtask

    task automatic test_underflow();
        do_reset();
        bus_if.core_done = 1;
        tick();
        bus_if.core_done = 0;
        checks++;
        if ({bus_if.err_underflow, bus_if.done_valid, bus_if.inflight} !== {1'b1, 1'b0, 3'd0}) begin
            failures++; $display("FAIL underflow err=%b dv=%b infl=%0d exp 1,0,0",
                bus_if.err_underflow, bus_if.done_valid, bus_if.inflight);
        end
        bus_if.req0 = 1; bus_if.mode0 = 2; bus_if.core_ready = 1; bus_if.core_done = 1;
        tick();
        bus_if.req0 = 0; bus_if.core_done = 0;
        checks++;
        if ({bus_if.ack0, bus_if.done_valid, bus_if.inflight} !== {1'b1, 1'b0, 3'd1}) begin
            failures++; $display("FAIL underflow_issue ack0=%b dv=%b infl=%0d exp 1,0,1",
                bus_if.ack0, bus_if.done_valid, bus_if.inflight);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus_if.err_underflow !== 1'b1) begin
            failures++; $display("FAIL underflow_sticky err=%b exp 1", bus_if.err_underflow);
        end
        resetn = 0;
        tick();
        resetn = 1;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++; $display("FAIL underflow_clear got=%h exp=%h", dut_vec(), RST_VEC);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_if.req0 = 1; bus_if.mode0 = 3; bus_if.core_ready = 1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (bus_if.inflight !== 3'd4) begin
            failures++; $display("FAIL reset_mid_fill infl=%0d exp 4", bus_if.inflight);
        end
        resetn = 0;
        tick();
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h", dut_vec(), RST_VEC);
        end
        resetn = 1; bus_if.req0 = 0; bus_if.core_done = 1;
        tick();
        bus_if.core_done = 0;
        checks++;
        if ({bus_if.err_underflow, bus_if.done_valid, bus_if.inflight} !== {1'b1, 1'b0, 3'd0}) begin
            failures++; $display("FAIL reset_mid_stale err=%b dv=%b infl=%0d exp 1,0,0",
                bus_if.err_underflow, bus_if.done_valid, bus_if.inflight);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (bus_if.ack0 || !bus_if.req0) begin
                bus_if.req0 = ($urandom_range(0, 99) < 60); bus_if.mode0 = 2'($urandom_range(0, 3));
            end
            if (bus_if.ack1 || !bus_if.req1) begin
                bus_if.req1 = ($urandom_range(0, 99) < 60); bus_if.mode1 = 2'($urandom_range(0, 3));
            end
            bus_if.core_ready = ($urandom_range(0, 99) < 80);
            bus_if.core_done  = ($urandom_range(0, 99) < 35);
            if (bus_if.flush) bus_if.flush = ($urandom_range(0, 99) >= 25);
            else              bus_if.flush = ($urandom_range(0, 99) < 5);
            resetn = ($urandom_range(0, 199) != 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL random cycle=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        clear_inputs();
        resetn = 1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_issue();
        test_contention();
        test_full_simul();
        test_flush();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
